seq_mul_radix2: RTL and testbench



---
 rtl/seq_mul_pkg.sv | 17 +
 rtl/seq_mul_negate.sv | 15 +
 rtl/seq_mul_radix2.sv | 142 ++++++++++++++
 tb/tb_seq_mul_radix2.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared types and helpers for the radix-2 sequential multiplier.
//   state_e   - FSM state encoding (IDLE / RUN / DONE)
//   cnt_width - step counter width for a given operand width
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Counter must hold 0..width-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mul_negate.sv
// seq_mul_negate: conditional two's-complement unit.
//   i_neg    in  1  negate when high
//   i_in     in  W  input value
//   o_out_c  out W  combinational result: i_neg ? -i_in : i_in
module seq_mul_negate #(
    parameter int unsigned W = 8
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_out_c
);

    assign o_out_c = i_neg ? (~i_in + W'(1)) : i_in;

endmodule

// File: rtl/seq_mul_radix2.sv
// seq_mul_radix2: sequential radix-2 shift-add multiplier, one multiplier bit
// per cycle, unsigned or two's-complement operands selected per operation.
// Optional feature macro: SEQ_MUL_EARLY_EXIT_EN (stop once remaining
// multiplier bits are all zero).
//   clk        in   1        rising-edge clock
//   rst_n      in   1        async active-low reset
//   in_valid   in   1        operand pair offered
//   in_ready   out  1        can accept operands (IDLE only)
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   is_signed  in   1        operands are two's complement
//   out_valid  out  1        product valid (DONE only)
//   out_ready  in   1        consumer accepts product
//   product    out  2*WIDTH  registered result
//   busy       out  1        high in RUN or DONE
module seq_mul_radix2
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_mcand;
    logic [PW-1:0]      r_product;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [PW-1:0]      w_acc_next;
    logic [PW-1:0]      w_prod_fix;
    logic [WIDTH-1:0]   w_mplier_shift;
    logic               w_last;
    logic               w_accept;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    assign w_a_neg = is_signed & a[WIDTH-1];
    assign w_b_neg = is_signed & b[WIDTH-1];

    seq_mul_negate #(.W(WIDTH)) u_neg_a (
        .i_neg   (w_a_neg),
        .i_in    (a),
        .o_out_c (w_a_mag)
    );

    seq_mul_negate #(.W(WIDTH)) u_neg_b (
        .i_neg   (w_b_neg),
        .i_in    (b),
        .o_out_c (w_b_mag)
    );

    // Shift-add step and sign fix of the updated accumulator.
    assign w_acc_next     = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_shift = r_mplier >> 1;

    seq_mul_negate #(.W(PW)) u_neg_p (
        .i_neg   (r_neg),
        .i_in    (w_acc_next),
        .o_out_c (w_prod_fix)
    );

`ifdef SEQ_MUL_EARLY_EXIT_EN
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (w_mplier_shift == '0);
`else
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

    assign w_accept = (r_state == IDLE) && in_valid;

    // Handshake outputs decode the state register only.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign product   = r_product;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, one shift-add step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (w_accept) begin
            r_acc     <= '0;
            r_mcand   <= PW'(w_a_mag);
            r_mplier  <= w_b_mag;
            r_cnt     <= '0;
            r_neg     <= w_a_neg ^ w_b_neg;
        end else if (r_state == RUN) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shift;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_product <= w_prod_fix;
            end
        end
    end

endmodule

// File: tb/tb_seq_mul_radix2.sv
// Testbench for seq_mul_radix2 (WIDTH=8): randomized and directed operands,
// expected products and latencies queued at accept, checked by a monitor.
module tb_seq_mul_radix2;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          is_signed;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;

    seq_mul_radix2 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PW-1:0] prod;
        int unsigned   acc_cyc;
        int unsigned   n;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Reference product: plain integer multiply of the operand values.
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = {{(64-W){aa[W-1]}}, aa};
            sb = {{(64-W){bb[W-1]}}, bb};
        end else begin
            sa = {{(64-W){1'b0}}, aa};
            sb = {{(64-W){1'b0}}, bb};
        end
        return PW'(sa * sb);
    endfunction

    // Expected RUN length for a multiplier value.
    function automatic int unsigned exp_n(input logic [W-1:0] bb, input logic s);
        logic [W-1:0] mag;
        int unsigned  n;
        mag = (s && bb[W-1]) ? (W'(0) - bb) : bb;
`ifdef SEQ_MUL_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < int'(W); i++) if (mag[i]) n = i + 1;
`else
        n = W;
        if (mag == '0) n = W;
`endif
        return n;
    endfunction

    // Monitor: compares each presented product against the queued expectation.
    logic        m_prev_valid = 1'b0;
    logic        m_hs_prev    = 1'b0;
    logic [PW-1:0] m_hold     = '0;
    exp_t        m_cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev_valid = 1'b0;
            m_hs_prev    = 1'b0;
        end else begin
            if (m_hs_prev) check("in_ready_after_handshake", 64'(in_ready), 64'(1));
            if (out_valid) begin
                check("busy_in_done", 64'(busy), 64'(1));
                check("in_ready_in_done", 64'(in_ready), 64'(0));
                if (!m_prev_valid) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_result actual=%0h required=none", product);
                        m_hold = product;
                    end else begin
                        m_cur = q.pop_front();
                        check("product", 64'(product), 64'(m_cur.prod));
                        check("latency", 64'(cyc - m_cur.acc_cyc), 64'(m_cur.n));
                        m_hold = m_cur.prod;
                    end
                end else begin
                    check("product_stable", 64'(product), 64'(m_hold));
                end
            end
            m_hs_prev    = out_valid && out_ready;
            m_prev_valid = out_valid && !out_ready;
        end
    end

    // Offer one operand pair, wait for the accept, queue its expectation.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                         output int unsigned acc);
        bit got;
        exp_t e;
        got      = 1'b0;
        acc      = 0;
        a        = ia;
        b        = ib;
        is_signed = is;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            e.prod    = ref_mul(ia, ib, is);
            e.acc_cyc = cyc + 1;
            e.n       = exp_n(ib, is);
            acc       = cyc + 1;
            q.push_back(e);
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        is_signed = 1'($urandom);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0 && in_ready) break;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vs;
    } vec_t;

    vec_t dir[10];

    initial begin
        int unsigned acc;
        int unsigned prev_acc;
        int unsigned prev_n;
        bit          seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        dir[0] = '{8'd15,  8'd15,  1'b0};
        dir[1] = '{8'hFF,  8'hFF,  1'b0};
        dir[2] = '{8'hFD,  8'h05,  1'b1};
        dir[3] = '{8'h80,  8'h80,  1'b1};
        dir[4] = '{8'hFF,  8'hFF,  1'b1};
        dir[5] = '{8'h7F,  8'h80,  1'b1};
        dir[6] = '{8'hA5,  8'h00,  1'b0};
        dir[7] = '{8'h5A,  8'h01,  1'b0};
        dir[8] = '{8'h33,  8'h80,  1'b0};
        dir[9] = '{8'h0C,  8'hFF,  1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_product", 64'(product), 64'(0));
        rst_n = 1'b1;

        // Directed: unsigned, signed and multiplier-length cases.
        for (int i = 0; i < 10; i++) issue(dir[i].va, dir[i].vb, dir[i].vs, acc);
        wait_drain();

        // Reset mid-RUN aborts immediately; the pending result is discarded.
        issue(8'h37, 8'h29, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 64'(out_valid), 64'(0));
        check("midrun_rst_busy", 64'(busy), 64'(0));
        check("midrun_rst_product", 64'(product), 64'(0));
        check("midrun_rst_in_ready", 64'(in_ready), 64'(1));
        q.delete();
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("held_rst_busy", 64'(busy), 64'(0));
        check("held_rst_in_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b0;
        rst_n    = 1'b1;
        issue(8'h9C, 8'h0D, 1'b1, acc);
        wait_drain();

        // Backpressure: DONE held with new operands offered.
        out_ready = 1'b0;
        issue(8'hC3, 8'h5A, 1'b1, acc);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout actual=out_valid_low required=out_valid_high");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a         = W'($urandom);
            b         = W'($urandom);
            is_signed = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Back-to-back random traffic in both modes.
        prev_acc = 0;
        prev_n   = 0;
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'(i % 2);
            issue(ra, rb, rs, acc);
            if (i > 0) check("result_spacing", 64'(acc - prev_acc), 64'(prev_n + 2));
            prev_acc = acc;
            prev_n   = exp_n(rb, rs);
        end
        wait_drain();

        repeat (5) @(posedge clk);
        check("queue_drained", 64'(q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
